// File: rtl/bt_pkg.sv
// Shared types for the branch target table: sizes, entry type and loader states.
package bt_pkg;

  localparam int D_BT       = 12;
  localparam int BT_ENTRIES = 8;
  localparam int BT_IDX_W   = $clog2(BT_ENTRIES);

  typedef logic [D_BT-1:0] bt_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } bt_state_e;

endpackage

// File: rtl/bt_regfile.sv
// ENTRIES x D table storage: one write port, synchronous clear, parallel read-out.
module bt_regfile #(
  parameter  int D       = 12,
  parameter  int ENTRIES = 8,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [D-1:0]  wdata,
  output logic [D-1:0]  rdata [ENTRIES-1:0]
);

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    // Each entry takes the whole word in one edge, so readers never see a partial target.
    always_ff @(posedge clk) begin
      if (clr)                          rdata[i] <= '0;
      else if (we && widx == IW'(i))    rdata[i] <= wdata;
    end
  end

endmodule

// File: rtl/branch_table_loader.sv
// Loads the branch target table from byte-wide memory (two bytes per entry)
// and accepts direct single-entry writes while idle.
module branch_table_loader
  import bt_pkg::*;
#(
  parameter  int D       = D_BT,
  parameter  int ENTRIES = BT_ENTRIES,
  parameter  int AW      = 8,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_rvalid,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [D-1:0]  wr_data,
  output logic [D-1:0]  branch_table [ENTRIES-1:0],
  output logic          busy,
  output logic          done,
  output logic          table_valid
);

  bt_state_e     state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [AW-1:0] base_q,  base_d;
  logic [7:0]    lo_q,    lo_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          valid_q, valid_d;

  logic          rf_we;
  logic [IW-1:0] rf_idx;
  logic [D-1:0]  rf_wdata;

  bt_regfile #(.D(D), .ENTRIES(ENTRIES)) u_rf (
    .clk   (clk),
    .clr   (reset),
    .we    (rf_we),
    .widx  (rf_idx),
    .wdata (rf_wdata),
    .rdata (branch_table)
  );

  // Next-state, memory request decode and table write-port mux.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    rf_we    = 1'b0;
    rf_idx   = wr_idx;
    rf_wdata = wr_data;
    case (state_q)
      IDLE: begin
        // A direct write in the same cycle as start still lands; the load overwrites it later.
        rf_we = wr_en;
        if (start) begin
          base_d  = base_addr;
          idx_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        mem_req  = 1'b1;
        mem_addr = base_q + AW'({idx_q, 1'b0});
        if (mem_rvalid) begin
          lo_d    = mem_rdata;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = base_q + AW'({idx_q, 1'b1});
        if (mem_rvalid) begin
          // High byte bits above the target width are dropped.
          rf_we    = 1'b1;
          rf_idx   = idx_q;
          rf_wdata = {mem_rdata[D-9:0], lo_q};
          if (idx_q == IW'(ENTRIES - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = RD_LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign table_valid = valid_q;

endmodule

// File: tb/tb_branch_table_loader.sv
// Randomized self-checking bench: a byte-stream reference model predicts the
// request addresses, table contents and status flags every cycle.
module tb_branch_table_loader;

  localparam int NE = 8;

  logic        clk = 1'b0;
  logic        reset, start, mem_rvalid, wr_en;
  logic [7:0]  base_addr;
  logic        mem_req;
  logic [7:0]  mem_addr, mem_rdata;
  logic [2:0]  wr_idx;
  logic [11:0] wr_data;
  logic [11:0] branch_table [NE-1:0];
  logic        busy, done, table_valid;

  logic [7:0]  mem [256];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  branch_table_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .branch_table (branch_table),
    .busy         (busy),
    .done         (done),
    .table_valid  (table_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [11:0] exp_tbl [NE];
  bit          exp_busy, exp_done, exp_valid;
  int          ld_pos;
  logic [7:0]  ld_base;
  int          mode;
  int          gcyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, gcyc);
    end
  endtask

  function automatic logic [11:0] entry_of(input logic [7:0] b, input int i);
    logic [7:0] a_lo, a_hi, lo, hi;
    a_lo = b + 8'(2 * i);
    a_hi = b + 8'(2 * i + 1);
    lo = mem[a_lo];
    hi = mem[a_hi];
    return {hi[3:0], lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) exp_tbl[i] = '0;
    exp_busy = 0; exp_done = 0; exp_valid = 0; ld_pos = 0; ld_base = '0;
  endtask

  // One clock: drive rvalid, check request side, advance model, clock, check outputs.
  task automatic tick();
    logic [7:0] ea;
    bit nd;
    case (mode)
      0:       mem_rvalid = 1'b1;
      1:       mem_rvalid = (gcyc % 3 == 2);
      default: mem_rvalid = 1'($urandom_range(0, 1));
    endcase
    chk("mem_req", mem_req, exp_busy);
    if (exp_busy) begin
      ea = ld_base + 8'(ld_pos);
      chk("mem_addr", mem_addr, ea);
    end
    nd = 0;
    if (reset) model_reset();
    else if (exp_busy) begin
      if (mem_rvalid) begin
        if (ld_pos % 2 == 1) exp_tbl[ld_pos / 2] = entry_of(ld_base, ld_pos / 2);
        ld_pos++;
        if (ld_pos == 2 * NE) begin exp_busy = 0; exp_valid = 1; nd = 1; end
      end
    end else begin
      if (wr_en) exp_tbl[wr_idx] = wr_data;
      if (start) begin exp_busy = 1; ld_pos = 0; ld_base = base_addr; exp_valid = 0; end
    end
    exp_done = nd;
    @(posedge clk);
    #1;
    gcyc++;
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("table_valid", table_valid, exp_valid);
    for (int i = 0; i < NE; i++) chk($sformatf("entry%0d", i), branch_table[i], exp_tbl[i]);
  endtask

  // wr_mode: 0 none, 1 direct write with start, 2 direct write mid-load.
  task automatic run_load(input logic [7:0] b, input int m, input int wr_mode,
                          input int abort_at, output int dcyc);
    mode = m;
    base_addr = b;
    start = 1;
    if (wr_mode == 1) begin wr_en = 1; wr_idx = 3'd3; wr_data = 12'hABC; end
    tick();
    if (wr_mode == 1) chk("wr_with_start", branch_table[3], 12'hABC);
    start = 0; wr_en = 0; dcyc = -1;
    for (int n = 1; n < 400; n++) begin
      if (done) begin dcyc = n; break; end
      if (n == abort_at) begin
        reset = 1; tick(); reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_req", mem_req, 0);
        for (int i = 0; i < NE; i++) chk("abort_clr", branch_table[i], 0);
        return;
      end
      chk("busy_hold", busy, 1);
      if (wr_mode == 2 && n == 5) begin wr_en = 1; wr_idx = 3'd3; wr_data = 12'h123; end
      tick();
      wr_en = 0;
    end
    if (dcyc < 0) chk("load_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, dc_slow;
    logic [11:0] ref_tbl [NE];
    reset = 1; start = 0; base_addr = '0; mem_rvalid = 0;
    wr_en = 0; wr_idx = '0; wr_data = '0; mode = 0; gcyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 16; k++) mem[8'h40 + k] = 8'(k + 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_mem_addr", mem_addr, 0);
    reset = 0;
    tick();

    // linear load, rvalid tied high
    run_load(8'h40, 0, 0, 0, dc);
    chk("done_cycle", dc, 17);
    chk("e0_val", branch_table[0], 12'h201);
    chk("e7_val", branch_table[7], 12'h00F);
    for (int i = 0; i < NE; i++) ref_tbl[i] = branch_table[i];
    tick();
    chk("done_pulse", done, 0);

    // same load, rvalid only every third cycle
    run_load(8'h40, 1, 0, 0, dc_slow);
    chk("slow_later", 32'(dc_slow > 17), 1);
    for (int i = 0; i < NE; i++) chk("slow_same", branch_table[i], ref_tbl[i]);

    // address wrap past top of memory
    run_load(8'hFC, 0, 0, 0, dc);
    chk("wrap_e2", branch_table[2], entry_of(8'hFC, 2));

    // direct write while idle
    mode = 0;
    wr_en = 1; wr_idx = 3'd3; wr_data = 12'hABC;
    tick();
    wr_en = 0;
    chk("direct_wr", branch_table[3], 12'hABC);
    chk("direct_valid", table_valid, 1);

    // direct write during a load is ignored
    run_load(8'h40, 0, 2, 0, dc);
    chk("busy_wr_ign", branch_table[3], 12'h807);

    // direct write together with start, later overwritten
    run_load(8'h40, 2, 1, 0, dc);
    chk("wr_overwr", branch_table[3], 12'h807);

    // reset mid-load, then a clean reload
    run_load(8'h40, 0, 0, 7, dc);
    tick();
    run_load(8'h40, 0, 0, 0, dc);
    chk("reload_done", dc, 17);

    // random loads with random idle writes
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mode = 2;
      for (int w = 0; w < 3; w++) begin
        wr_en = 1; wr_idx = 3'($urandom); wr_data = 12'($urandom);
        tick();
      end
      wr_en = 0;
      run_load(8'($urandom), 2, 0, (r == 3) ? 11 : 0, dc);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
